decimator: RTL and testbench

Stream decimator that sits directly downstream of the low-pass FIR stage. It consumes the filtered, anti-aliased stream and outputs one sample per M accepted input samples. It keeps the team's dstream valid/ready handshake on both sides. A 2-entry output buffer lets the stage absorb backpressure without creating a combinational ready path from output to input.

---
 rtl/decimator_if.sv | 22 ++
 rtl/decimator.sv | 204 ++++++++++++++++++++
 tb/tb_decimator.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decimator_if.sv
// ---------------------------------------------------------------------------
// decimator_if : dstream valid/ready handshake bundle.
//
// Signals
//   data  : W-bit signed sample, driven by the producer
//   valid : producer has a sample on data this cycle
//   ready : consumer can take the sample this cycle
//
// Modports
//   master : producer side (drives data/valid, receives ready)
//   slave  : consumer side (receives data/valid, drives ready)
// ---------------------------------------------------------------------------
interface decimator_if #(
  parameter int W = 16
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/decimator.sv
// ---------------------------------------------------------------------------
// decimator : stream decimator placed after the low-pass FIR stage.
//
// Emits one sample for every M accepted input samples. Default build keeps
// the sample at position PHASE of every group of M (bit-exact pass-through).
// With the macro DECIM_AVG_EN defined the block becomes a boxcar-average
// decimator: every group of M samples is summed and the mean (arithmetic
// shift by log2(M), rounding toward -inf) is emitted; PHASE is then ignored
// and M must be a power of two.
//
// A 2-entry output FIFO absorbs downstream backpressure. x.ready depends
// only on registered state, so there is no combinational y.ready -> x.ready
// path. y.data and y.valid come straight from flops.
//
// Ports
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   x     : decimator_if.slave  - input stream (data, valid in; ready out)
//   y     : decimator_if.master - output stream (data, valid out; ready in)
//
// Parameters
//   W     : sample width (signed two's complement)
//   M     : decimation factor, 2..256
//   PHASE : kept index within each group of M, 0..M-1
// ---------------------------------------------------------------------------
module decimator #(
  parameter int W     = 16,
  parameter int M     = 4,
  parameter int PHASE = 0
) (
  input  logic           clk,
  input  logic           reset,
  decimator_if.slave     x,
  decimator_if.master    y
);

  localparam int CW = $clog2(M);

`ifdef DECIM_AVG_EN
  localparam bit AVG_EN = 1'b1;
`else
  localparam bit AVG_EN = 1'b0;
`endif

  // Averaging always emits on the last sample of a group.
  localparam int            EMIT     = AVG_EN ? (M - 1) : PHASE;
  localparam logic [CW-1:0] EMIT_CNT = CW'(EMIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(M - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [1:0]    count_q,   count_d;
  logic [W-1:0]  head_q,    head_d;
  logic [W-1:0]  tail_q,    tail_d;
  logic          y_valid_q, y_valid_d;

  logic          is_emit_s;
  logic          x_ready_s;
  logic          x_fire_s;
  logic          y_fire_s;
  logic          push_s;
  logic          pop_s;
  logic [W-1:0]  push_data_s;

  assign is_emit_s = (cnt_q == EMIT_CNT);
  // Only the emit slot can need buffer space; other samples are always taken.
  assign x_ready_s = (count_q != 2'd2) || !is_emit_s;
  assign x_fire_s  = x.valid && x_ready_s;
  assign y_fire_s  = y_valid_q && y.ready;
  assign push_s    = x_fire_s && is_emit_s;
  assign pop_s     = y_fire_s;

  assign x.ready = x_ready_s;
  assign y.valid = y_valid_q;
  assign y.data  = head_q;

`ifdef DECIM_AVG_EN
  // ---------------------------------------------------------------------
  // Boxcar accumulator (W + log2(M) bits, so a full group cannot overflow)
  // ---------------------------------------------------------------------
  localparam int AW = W + CW;

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] x_ext_s;
  logic signed [AW-1:0] sum_s;

  assign x_ext_s = {{CW{x.data[W-1]}}, x.data};
  assign sum_s   = acc_q + x_ext_s;
  // Top W bits of the full sum are the floor-mean of the group.
  assign push_data_s = W'(sum_s >>> CW);

  // Next accumulator value: load on first sample, add in middle, clear on emit.
  always_comb begin
    acc_d = acc_q;
    if (x_fire_s) begin
      if (cnt_q == {CW{1'b0}}) begin
        acc_d = x_ext_s;
      end else if (cnt_q == LAST_CNT) begin
        acc_d = {AW{1'b0}};
      end else begin
        acc_d = sum_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= {AW{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  assign push_data_s = x.data;
`endif

  // Phase counter: advances on every accepted input, wraps after M-1.
  always_comb begin
    cnt_d = cnt_q;
    if (x_fire_s) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output FIFO next state; head is always the oldest buffered sample.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push_s, pop_s})
      2'b10: begin
        case (count_q)
          2'd0: begin
            head_d  = push_data_s;
            count_d = 2'd1;
          end
          2'd1: begin
            tail_d  = push_data_s;
            count_d = 2'd2;
          end
          default: begin
            count_d = count_q;
          end
        endcase
      end
      2'b01: begin
        case (count_q)
          2'd1: begin
            count_d = 2'd0;
          end
          2'd2: begin
            head_d  = tail_q;
            count_d = 2'd1;
          end
          default: begin
            count_d = count_q;
          end
        endcase
      end
      2'b11: begin
        // Only reachable with one entry: the pushed sample replaces the head.
        if (count_q == 2'd1) begin
          head_d  = push_data_s;
          count_d = 2'd1;
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
    y_valid_d = (count_d != 2'd0);
  end

  // Counter, FIFO and output-valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= {CW{1'b0}};
      count_q   <= 2'd0;
      head_q    <= {W{1'b0}};
      tail_q    <= {W{1'b0}};
      y_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      y_valid_q <= y_valid_d;
    end
  end

endmodule

// File: tb/tb_decimator.sv
// ---------------------------------------------------------------------------
// tb_decimator : self-checking bench for decimator.
// Two instances: dut_a (PHASE=0) and dut_b (PHASE=3). Accepted inputs and
// output transfers are recorded in queues; expected outputs are computed
// from the accepted inputs by grouping them in blocks of M.
// ---------------------------------------------------------------------------
module tb_decimator;

  localparam int W    = 16;
  localparam int M    = 4;
  localparam int PH_A = 0;
  localparam int PH_B = 3;

`ifdef DECIM_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decimator_if #(.W(W)) xa ();
  decimator_if #(.W(W)) ya ();
  decimator_if #(.W(W)) xb ();
  decimator_if #(.W(W)) yb ();

  decimator #(.W(W), .M(M), .PHASE(PH_A)) dut_a (.clk(clk), .reset(reset), .x(xa), .y(ya));
  decimator #(.W(W), .M(M), .PHASE(PH_B)) dut_b (.clk(clk), .reset(reset), .x(xb), .y(yb));

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  int stim_q[$];
  int in_q[$];
  int in_t[$];
  int out_q[$];
  int out_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Index inside a group of M that produces an output.
  function automatic int emit_idx(input int ph);
    return AVG ? (M - 1) : ph;
  endfunction

  // Number of outputs produced by the first n accepted inputs.
  function automatic int n_pushes(input int n, input int ph);
    if (AVG) return n / M;
    return (n / M) + (((n % M) > ph) ? 1 : 0);
  endfunction

  // Expected k-th output from the recorded accepted inputs.
  function automatic int expect_k(input int k, input int ph);
    int s;
    int q;
    if (AVG) begin
      s = 0;
      for (int j = 0; j < M; j++) s += in_q[k*M + j];
      q = s / M;
      if ((s % M != 0) && (s < 0)) q = q - 1;
      return q;
    end
    return in_q[k*M + ph];
  endfunction

  task automatic clear_q();
    stim_q.delete();
    in_q.delete();
    in_t.delete();
    out_q.delete();
    out_t.delete();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    xa.valid = 1'b0; xa.data = '0; ya.ready = 1'b1;
    xb.valid = 1'b0; xb.data = '0; yb.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_q();
  endtask

  task automatic ramp(input int start, input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(start + i);
  endtask

  // Drives stim_q into one DUT; counts x.ready cycles that disagree with
  // the buffer occupancy implied by the transfers seen so far.
  task automatic drive(input int sel, input int vpct, input int rpct, input int budget,
                       input int want_out, output int bad_ready, output bit timeout);
    int ph, c, n, pend;
    logic v, r, xr, yv, exp_r;
    logic [W-1:0] dval, yd;
    ph = (sel == 0) ? PH_A : PH_B;
    c = 0;
    bad_ready = 0;
    timeout = 1'b0;
    while (in_q.size() < stim_q.size() || out_q.size() < want_out) begin
      if (c >= budget) begin
        timeout = 1'b1;
        break;
      end
      n = in_q.size();
      v = (n < stim_q.size()) && ($urandom_range(0, 99) < vpct);
      r = ($urandom_range(0, 99) < rpct);
      dval = (n < stim_q.size()) ? W'(stim_q[n]) : '0;
      if (sel == 0) begin xa.valid = v; xa.data = dval; ya.ready = r; end
      else          begin xb.valid = v; xb.data = dval; yb.ready = r; end
      @(negedge clk);
      if (sel == 0) begin xr = xa.ready; yv = ya.valid; yd = ya.data; end
      else          begin xr = xb.ready; yv = yb.valid; yd = yb.data; end
      pend  = n_pushes(n, ph) - out_q.size();
      exp_r = !((pend == 2) && ((n % M) == emit_idx(ph)));
      if (xr !== exp_r) bad_ready++;
      if (v && xr) begin in_q.push_back(stim_q[n]); in_t.push_back(cyc + 1); end
      if (yv && r) begin out_q.push_back(int'($signed(yd))); out_t.push_back(cyc + 1); end
      @(posedge clk);
      #1;
      c++;
    end
    if (sel == 0) xa.valid = 1'b0;
    else          xb.valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (ya.valid !== 1'b0) $display("FAIL reset_a_valid got=%b exp=0", ya.valid); else passed++;
    total++; if (ya.data !== 16'h0000) $display("FAIL reset_a_data got=%h exp=0", ya.data); else passed++;
    total++; if (xa.ready !== 1'b1) $display("FAIL reset_a_ready got=%b exp=1", xa.ready); else passed++;
    total++; if (yb.valid !== 1'b0) $display("FAIL reset_b_valid got=%b exp=0", yb.valid); else passed++;
    total++; if (yb.data !== 16'h0000) $display("FAIL reset_b_data got=%h exp=0", yb.data); else passed++;
    total++; if (xb.ready !== 1'b1) $display("FAIL reset_b_ready got=%b exp=1", xb.ready); else passed++;
  endtask

  // Continuous ramp 0..15 through one instance, checking values and latency.
  task automatic test_pick(input int sel);
    int bad, nexp, ph;
    bit to;
    ph = (sel == 0) ? PH_A : PH_B;
    do_reset();
    ramp(0, 16);
    nexp = n_pushes(16, ph);
    drive(sel, 100, 100, 200, nexp, bad, to);
    total++; if (to !== 1'b0) $display("FAIL pick%0d_timeout got=%0d exp=0", sel, to); else passed++;
    total++; if (bad !== 0) $display("FAIL pick%0d_xready bad_cycles=%0d exp=0", sel, bad); else passed++;
    total++; if (out_q.size() !== nexp) $display("FAIL pick%0d_count got=%0d exp=%0d", sel, out_q.size(), nexp); else passed++;
    for (int k = 0; k < nexp && k < out_q.size(); k++) begin
      total++;
      if (out_q[k] !== expect_k(k, ph)) $display("FAIL pick%0d_data[%0d] got=%0d exp=%0d", sel, k, out_q[k], expect_k(k, ph));
      else passed++;
      total++;
      if (out_t[k] !== in_t[k*M + emit_idx(ph)] + 1)
        $display("FAIL pick%0d_latency[%0d] got=%0d exp=%0d", sel, k, out_t[k], in_t[k*M + emit_idx(ph)] + 1);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int bad, stall_n, nexp;
    bit to;
    do_reset();
    ramp(0, 16);
    stall_n = 0;
    while (!((n_pushes(stall_n, PH_A) == 2) && ((stall_n % M) == emit_idx(PH_A)))) stall_n++;
    drive(0, 100, 0, 20, 0, bad, to);
    total++; if (bad !== 0) $display("FAIL bp_hold_xready bad_cycles=%0d exp=0", bad); else passed++;
    total++; if (in_q.size() !== stall_n) $display("FAIL bp_accepted got=%0d exp=%0d", in_q.size(), stall_n); else passed++;
    total++; if (ya.valid !== 1'b1) $display("FAIL bp_valid got=%b exp=1", ya.valid); else passed++;
    total++; if (int'($signed(ya.data)) !== expect_k(0, PH_A)) $display("FAIL bp_head got=%0d exp=%0d", $signed(ya.data), expect_k(0, PH_A)); else passed++;
    nexp = n_pushes(16, PH_A);
    drive(0, 100, 100, 200, nexp, bad, to);
    total++; if (to !== 1'b0) $display("FAIL bp_timeout got=%0d exp=0", to); else passed++;
    total++; if (bad !== 0) $display("FAIL bp_release_xready bad_cycles=%0d exp=0", bad); else passed++;
    total++; if (out_q.size() !== nexp) $display("FAIL bp_count got=%0d exp=%0d", out_q.size(), nexp); else passed++;
    for (int k = 0; k < nexp && k < out_q.size(); k++) begin
      total++;
      if (out_q[k] !== expect_k(k, PH_A)) $display("FAIL bp_data[%0d] got=%0d exp=%0d", k, out_q[k], expect_k(k, PH_A));
      else passed++;
    end
  endtask

  task automatic test_random();
    int bad, nexp;
    bit to;
    do_reset();
    ramp(0, 64);
    nexp = n_pushes(64, PH_A);
    drive(0, 50, 50, 3000, nexp, bad, to);
    total++; if (to !== 1'b0) $display("FAIL rnd_timeout got=%0d exp=0", to); else passed++;
    total++; if (bad !== 0) $display("FAIL rnd_xready bad_cycles=%0d exp=0", bad); else passed++;
    total++; if (out_q.size() !== nexp) $display("FAIL rnd_count got=%0d exp=%0d", out_q.size(), nexp); else passed++;
    for (int k = 0; k < nexp && k < out_q.size(); k++) begin
      total++;
      if (out_q[k] !== expect_k(k, PH_A)) $display("FAIL rnd_data[%0d] got=%0d exp=%0d", k, out_q[k], expect_k(k, PH_A));
      else passed++;
    end
  endtask

  task automatic test_reset_midstream();
    int bad, nexp;
    bit to;
    do_reset();
    ramp(0, 6);
    drive(0, 100, 0, 50, 0, bad, to);
    total++; if (in_q.size() !== 6) $display("FAIL mid_accepted got=%0d exp=6", in_q.size()); else passed++;
    total++; if (ya.valid !== 1'b1) $display("FAIL mid_pre_valid got=%b exp=1", ya.valid); else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++; if (ya.valid !== 1'b0) $display("FAIL mid_async_valid got=%b exp=0", ya.valid); else passed++;
    total++; if (ya.data !== 16'h0000) $display("FAIL mid_async_data got=%h exp=0", ya.data); else passed++;
    total++; if (xa.ready !== 1'b1) $display("FAIL mid_async_ready got=%b exp=1", xa.ready); else passed++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_q();
    ramp(100, 8);
    nexp = n_pushes(8, PH_A);
    drive(0, 100, 100, 100, nexp, bad, to);
    total++; if (bad !== 0) $display("FAIL mid_after_xready bad_cycles=%0d exp=0", bad); else passed++;
    total++;
    if (out_q.size() < 1) $display("FAIL mid_first_out got=none exp=%0d", expect_k(0, PH_A));
    else if (out_q[0] !== expect_k(0, PH_A)) $display("FAIL mid_first_out got=%0d exp=%0d", out_q[0], expect_k(0, PH_A));
    else passed++;
  endtask

  // Fixed signed pattern with hand-computed results.
  task automatic test_values();
    int bad;
    int e0, e1;
    bit to;
    do_reset();
    stim_q = '{1, 2, 3, 4, -1, -2, -3, -5};
`ifdef DECIM_AVG_EN
    e0 = 2;  e1 = -3;
`else
    e0 = 1;  e1 = -1;
`endif
    drive(0, 100, 100, 100, 2, bad, to);
    total++; if (out_q.size() !== 2) $display("FAIL val_count got=%0d exp=2", out_q.size()); else passed++;
    total++;
    if (out_q.size() < 1 || out_q[0] !== e0) $display("FAIL val_out0 got=%0d exp=%0d", (out_q.size() > 0) ? out_q[0] : 0, e0);
    else passed++;
    total++;
    if (out_q.size() < 2 || out_q[1] !== e1) $display("FAIL val_out1 got=%0d exp=%0d", (out_q.size() > 1) ? out_q[1] : 0, e1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_pick(0);
    test_pick(1);
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_values();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
